// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: 2-flop sync, tick-sampled per-bit debounce, edge pulses and
// a sticky change mask behind a valid/ack handshake. Define SW_LED_MIRROR_EN for a registered LED mirror.

module sw_db_lane #(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d, rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync == db_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        db_d   = ~db_q;
        rise_d = ~db_q;
        fall_d = db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

module sw_conditioner #(
  parameter int N_SW         = 16,
  parameter int TICK_CYCLES  = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  input  logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] SW_DB,
  output logic [N_SW-1:0] SW_RISE,
  output logic [N_SW-1:0] SW_FALL,
  output logic            EVT_VALID,
  output logic [N_SW-1:0] EVT_MASK,
  output logic            EVT_OVF,
  input  logic            EVT_ACK
`ifdef SW_LED_MIRROR_EN
  ,
  output logic [N_SW-1:0] LED
`endif
);
  localparam int PW = $clog2(TICK_CYCLES);

  logic [N_SW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            tick;
  logic [N_SW-1:0] mask_q, mask_d, chg;
  logic            valid_q, valid_d, ovf_q, ovf_d, ack_acc;

  assign tick = (pre_q == PW'(TICK_CYCLES - 1));

  always_comb begin
    sync1_d = SW;
    sync2_d = sync1_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);
  end

  sw_db_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane [N_SW-1:0] (
    .clk  (CLK100MHZ),
    .rst_n(CPU_RESETN),
    .sync (sync2_q),
    .tick (tick),
    .db   (SW_DB),
    .rise (SW_RISE),
    .fall (SW_FALL)
  );

  assign chg     = SW_RISE | SW_FALL;
  assign ack_acc = EVT_ACK & valid_q;

  // An ack clears overflow even if a repeat change lands in the same cycle:
  // the mask was just consumed, so that change starts a fresh event.
  always_comb begin
    if (ack_acc) begin
      mask_d = chg;
      ovf_d  = 1'b0;
    end else begin
      mask_d = mask_q | chg;
      ovf_d  = ovf_q | (|(chg & mask_q));
    end
    valid_d = |mask_d;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pre_q   <= pre_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign EVT_MASK  = mask_q;
  assign EVT_VALID = valid_q;
  assign EVT_OVF   = ovf_q;

`ifdef SW_LED_MIRROR_EN
  logic [N_SW-1:0] led_q, led_d;
  assign led_d = SW_DB;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) led_q <= '0;
    else             led_q <= led_d;
  end
  assign LED = led_q;
`endif
endmodule
